// File: rtl/monim_sm_ctrl_if.sv
// Control, sample and result signals of the monitor sampling scheduler.
// The master side drives requests and raw samples; the slave side returns captures.
interface monim_sm_ctrl_if #(
    parameter int DW = 32,
    parameter int PW = 16
);
    logic          enable_i;
    logic [PW-1:0] period_i;
    logic          single_i;
    logic          freeze_i;
    logic          ack_i;
    logic          clr_i;
    logic [DW-1:0] data_p_sm_1_i;
    logic [DW-1:0] data_p_sm_2_i;
    logic [DW-1:0] p_sm_1_o;
    logic [DW-1:0] p_sm_2_o;
    logic          valid_o;
    logic [15:0]   seq_o;
    logic [7:0]    drop_cnt_o;
    logic [1:0]    state_o;

    modport master (
        output enable_i, period_i, single_i, freeze_i, ack_i, clr_i,
        output data_p_sm_1_i, data_p_sm_2_i,
        input  p_sm_1_o, p_sm_2_o, valid_o, seq_o, drop_cnt_o, state_o
    );

    modport slave (
        input  enable_i, period_i, single_i, freeze_i, ack_i, clr_i,
        input  data_p_sm_1_i, data_p_sm_2_i,
        output p_sm_1_o, p_sm_2_o, valid_o, seq_o, drop_cnt_o, state_o
    );
endinterface

// File: rtl/monim_sm_ctrl.sv
// Sampling scheduler: periodic/one-shot capture of the sample pair,
// freeze while the reader holds it, drop counting and catch-up capture.
module monim_sm_ctrl #(
    parameter int DW = 32,
    parameter int PW = 16
) (
    input logic           clk_i,
    input logic           arst_ni,
    monim_sm_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        CATCH = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d, run_cnt;
    logic          pend_q, pend_d;
    logic [DW-1:0] p1_q, p2_q;
    logic          valid_q;
    logic [15:0]   seq_q;
    logic [7:0]    drop_q;
    logic          tick, req, cap, drop_ev;

    always_comb begin
        tick    = 1'b0;
        req     = 1'b0;
        run_cnt = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        cap     = 1'b0;
        drop_ev = 1'b0;

        tick = (state_q == RUN || state_q == HOLD) &&
               bus.enable_i && (cnt_q == '0);
        req  = tick || bus.single_i;

        // free-running countdown shared by RUN, HOLD and CATCH
        if (bus.enable_i)
            run_cnt = (cnt_q == '0) ? bus.period_i : cnt_q - PW'(1);

        unique case (state_q)
            IDLE: begin
                cnt_d = bus.enable_i ? bus.period_i : '0;
                if (bus.freeze_i) begin
                    state_d = HOLD;
                end else begin
                    cap = bus.single_i;
                    if (bus.enable_i)
                        state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = run_cnt;
                if (bus.freeze_i) begin
                    state_d = HOLD;
                end else if (!bus.enable_i) begin
                    state_d = IDLE;
                    cap     = bus.single_i;
                end else begin
                    cap = req;
                    if (bus.single_i)
                        cnt_d = bus.period_i;
                end
            end
            HOLD: begin
                cnt_d = run_cnt;
                if (req) begin
                    pend_d  = 1'b1;
                    drop_ev = 1'b1;
                end
                if (!bus.freeze_i) begin
                    if (pend_q || req)
                        state_d = CATCH;
                    else if (bus.enable_i)
                        state_d = RUN;
                    else
                        state_d = IDLE;
                end
            end
            CATCH: begin
                cnt_d  = run_cnt;
                cap    = 1'b1;
                pend_d = 1'b0;
                if (bus.freeze_i)
                    state_d = HOLD;
                else if (bus.enable_i)
                    state_d = RUN;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            p1_q    <= '0;
            p2_q    <= '0;
            valid_q <= 1'b0;
            seq_q   <= '0;
        end else if (cap) begin
            p1_q    <= bus.data_p_sm_1_i;
            p2_q    <= bus.data_p_sm_2_i;
            valid_q <= 1'b1;
            seq_q   <= seq_q + 16'd1;
        end else if (bus.ack_i) begin
            valid_q <= 1'b0;
        end
    end

    // clear wins over count, but a simultaneous drop still registers as one
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)
            drop_q <= '0;
        else if (bus.clr_i)
            drop_q <= {7'd0, drop_ev};
        else if (drop_ev && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign bus.p_sm_1_o   = p1_q;
    assign bus.p_sm_2_o   = p2_q;
    assign bus.valid_o    = valid_q;
    assign bus.seq_o      = seq_q;
    assign bus.drop_cnt_o = drop_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_monim_sm_ctrl.sv
// Bench for monim_sm_ctrl: vector table, directed corner sequences and
// random traffic compared against a timeline-based reference model.
module tb_monim_sm_ctrl;
    logic clk_i = 1'b0;
    logic arst_ni = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk_i = ~clk_i;

    monim_sm_ctrl_if #(.DW(32), .PW(16)) bus ();

    monim_sm_ctrl #(.DW(32), .PW(16)) dut (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic        en;
        logic [15:0] per;
        logic        sg, fr, ak, cl;
        logic [31:0] d1, d2;
        logic        ev;
        logic [15:0] es;
        logic [7:0]  ed;
        logic [1:0]  est;
        logic [31:0] ep1, ep2;
    } vec_t;

    vec_t tbl [19];

    // reference model: timer kept as the absolute cycle of the next zero
    longint cyc = 0;
    longint m_next = 0;
    int     m_mode = 0;
    bit     m_pend = 0;
    logic [31:0] m_p1 = 0, m_p2 = 0;
    bit     m_valid = 0;
    int     m_seq = 0;
    int     m_drop = 0;

    function automatic vec_t mk(
        logic en, logic [15:0] per, logic sg, logic fr, logic ak, logic cl,
        logic [31:0] d1, logic [31:0] d2, logic ev, logic [15:0] es,
        logic [7:0] ed, logic [1:0] est, logic [31:0] ep1, logic [31:0] ep2);
        vec_t v;
        v.en = en; v.per = per; v.sg = sg; v.fr = fr; v.ak = ak; v.cl = cl;
        v.d1 = d1; v.d2 = d2; v.ev = ev; v.es = es; v.ed = ed; v.est = est;
        v.ep1 = ep1; v.ep2 = ep2;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(string nm);
        chk({nm, ".p1"}, bus.p_sm_1_o, m_p1);
        chk({nm, ".p2"}, bus.p_sm_2_o, m_p2);
        chk({nm, ".valid"}, {31'd0, bus.valid_o}, {31'd0, m_valid});
        chk({nm, ".seq"}, {16'd0, bus.seq_o}, m_seq);
        chk({nm, ".drop"}, {24'd0, bus.drop_cnt_o}, m_drop);
        chk({nm, ".state"}, {30'd0, bus.state_o}, m_mode);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_p1 = 0; m_p2 = 0;
        m_valid = 0; m_seq = 0; m_drop = 0;
        m_next = cyc;
    endtask

    task automatic model_step();
        longint c = cyc;
        bit en = bus.enable_i, sg = bus.single_i, fr = bus.freeze_i;
        bit tick, req, cap, drp;
        int nm;
        tick = (m_mode == 1 || m_mode == 2) && en && (m_next == c);
        req = tick || sg;
        cap = 0; drp = 0; nm = m_mode;
        if (m_mode == 0)
            m_next = en ? c + 1 + longint'(bus.period_i) : c + 1;
        else if (!en)
            m_next = c + 1;
        else if (m_next == c || (m_mode == 1 && sg && !fr))
            m_next = c + 1 + longint'(bus.period_i);
        case (m_mode)
            0: if (fr) nm = 2; else begin cap = sg; if (en) nm = 1; end
            1: if (fr) nm = 2;
               else if (!en) begin nm = 0; cap = sg; end
               else cap = req;
            2: begin
                if (req) begin m_pend = 1; drp = 1; end
                if (!fr) nm = m_pend ? 3 : (en ? 1 : 0);
            end
            default: begin
                cap = 1; m_pend = 0;
                nm = fr ? 2 : (en ? 1 : 0);
            end
        endcase
        if (cap) begin
            m_p1 = bus.data_p_sm_1_i; m_p2 = bus.data_p_sm_2_i;
            m_valid = 1; m_seq = (m_seq + 1) % 65536;
        end else if (bus.ack_i) begin
            m_valid = 0;
        end
        if (bus.clr_i) m_drop = drp ? 1 : 0;
        else if (drp && m_drop < 255) m_drop++;
        m_mode = nm;
        cyc++;
    endtask

    task automatic drive(bit en, logic [15:0] per, bit sg, bit fr, bit ak,
                         bit cl, logic [31:0] d1, logic [31:0] d2);
        bus.enable_i = en; bus.period_i = per; bus.single_i = sg;
        bus.freeze_i = fr; bus.ack_i = ak; bus.clr_i = cl;
        bus.data_p_sm_1_i = d1; bus.data_p_sm_2_i = d2;
    endtask

    task automatic step(bit do_chk, string nm);
        @(posedge clk_i);
        model_step();
        #1;
        if (do_chk) chk_model(nm);
    endtask

    task automatic do_reset();
        arst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        model_reset();
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit fr, en;
        logic [31:0] base;

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.p1", bus.p_sm_1_o, 32'd0);
        chk("rst.p2", bus.p_sm_2_o, 32'd0);
        chk("rst.valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst.seq", {16'd0, bus.seq_o}, 32'd0);
        chk("rst.drop", {24'd0, bus.drop_cnt_o}, 32'd0);
        chk("rst.state", {30'd0, bus.state_o}, 32'd0);
        arst_ni = 1'b1;
        model_reset();

        tbl[0]  = mk(0,0,1,0,0,0, 32'hA5A50001,32'h5A5A0002, 1,1,0,0, 32'hA5A50001,32'h5A5A0002);
        tbl[1]  = mk(0,0,0,0,1,0, 32'h11,32'h111, 0,1,0,0, 32'hA5A50001,32'h5A5A0002);
        tbl[2]  = mk(1,1,0,0,0,0, 32'h22,32'h122, 0,1,0,1, 32'hA5A50001,32'h5A5A0002);
        tbl[3]  = mk(1,1,0,0,0,0, 32'h33,32'h133, 0,1,0,1, 32'hA5A50001,32'h5A5A0002);
        tbl[4]  = mk(1,1,0,0,0,0, 32'h44,32'h144, 1,2,0,1, 32'h44,32'h144);
        tbl[5]  = mk(1,1,0,0,1,0, 32'h55,32'h155, 0,2,0,1, 32'h44,32'h144);
        tbl[6]  = mk(1,1,0,0,1,0, 32'h66,32'h166, 1,3,0,1, 32'h66,32'h166);
        tbl[7]  = mk(1,1,0,1,0,0, 32'h77,32'h177, 1,3,0,2, 32'h66,32'h166);
        tbl[8]  = mk(1,1,0,1,0,0, 32'h88,32'h188, 1,3,1,2, 32'h66,32'h166);
        tbl[9]  = mk(1,1,0,1,0,1, 32'h99,32'h199, 1,3,0,2, 32'h66,32'h166);
        tbl[10] = mk(1,1,0,1,0,1, 32'hAA,32'h1AA, 1,3,1,2, 32'h66,32'h166);
        tbl[11] = mk(1,1,0,0,0,0, 32'hBB,32'h1BB, 1,3,1,3, 32'h66,32'h166);
        tbl[12] = mk(1,1,0,0,0,0, 32'hCC,32'h1CC, 1,4,1,1, 32'hCC,32'h1CC);
        tbl[13] = mk(1,1,1,0,0,0, 32'hDD,32'h1DD, 1,5,1,1, 32'hDD,32'h1DD);
        tbl[14] = mk(1,1,0,0,0,0, 32'hEE,32'h1EE, 1,5,1,1, 32'hDD,32'h1DD);
        tbl[15] = mk(1,1,1,0,0,0, 32'hF0,32'h1F0, 1,6,1,1, 32'hF0,32'h1F0);
        tbl[16] = mk(0,1,1,0,0,0, 32'h101,32'h201, 1,7,1,0, 32'h101,32'h201);
        tbl[17] = mk(0,1,1,1,0,0, 32'h102,32'h202, 1,7,1,2, 32'h101,32'h201);
        tbl[18] = mk(0,1,0,0,0,0, 32'h103,32'h203, 1,7,1,0, 32'h101,32'h201);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].en, tbl[i].per, tbl[i].sg, tbl[i].fr, tbl[i].ak,
                  tbl[i].cl, tbl[i].d1, tbl[i].d2);
            step(0, "");
            chk($sformatf("vec%0d.p1", i), bus.p_sm_1_o, tbl[i].ep1);
            chk($sformatf("vec%0d.p2", i), bus.p_sm_2_o, tbl[i].ep2);
            chk($sformatf("vec%0d.valid", i), {31'd0, bus.valid_o}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d.seq", i), {16'd0, bus.seq_o}, {16'd0, tbl[i].es});
            chk($sformatf("vec%0d.drop", i), {24'd0, bus.drop_cnt_o}, {24'd0, tbl[i].ed});
            chk($sformatf("vec%0d.state", i), {30'd0, bus.state_o}, {30'd0, tbl[i].est});
        end

        // periodic capture, period 3, enabled from reset release
        do_reset();
        for (int i = 1; i <= 13; i++) begin
            drive(1, 3, 0, 0, 0, 0, i, i << 8);
            step(1, "per");
            if (i == 4) chk("per.seq0", {16'd0, bus.seq_o}, 32'd0);
            if (i == 5 || i == 9 || i == 13) begin
                chk("per.seq", {16'd0, bus.seq_o}, (i - 1) / 4);
                chk("per.p1", bus.p_sm_1_o, i);
                chk("per.p2", bus.p_sm_2_o, i << 8);
            end
        end

        // freeze for 6 cycles with period 1, then catch-up
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0, 32'h300 + i, 32'h400 + i);
            step(1, "frz.pre");
        end
        base = m_seq;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 1, 0, 0, 32'h500 + i, 32'h600 + i);
            step(1, "frz.hold");
        end
        drive(1, 1, 0, 0, 0, 0, 32'h700, 32'h800);
        step(1, "frz.rel");
        chk("frz.drop", {24'd0, bus.drop_cnt_o}, 32'd3);
        chk("frz.seqhold", {16'd0, bus.seq_o}, base);
        chk("frz.catch", {30'd0, bus.state_o}, 32'd3);
        drive(1, 1, 0, 0, 0, 0, 32'h701, 32'h801);
        step(1, "frz.cap");
        chk("frz.seq1", {16'd0, bus.seq_o}, base + 1);
        chk("frz.p1", bus.p_sm_1_o, 32'h701);

        // drop counter saturation
        do_reset();
        for (int i = 0; i < 302; i++) begin
            drive(1, 0, 0, 1, 0, 0, 0, 0);
            step(0, "");
        end
        chk_model("sat");
        chk("sat.drop", {24'd0, bus.drop_cnt_o}, 32'd255);

        // sequence wrap
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            drive(1, 0, 0, 0, 1, 0, i, ~i);
            step(0, "");
        end
        chk("wrap.ffff", {16'd0, bus.seq_o}, 32'h0000FFFF);
        drive(1, 0, 0, 0, 0, 0, 32'hC0FFEE, 32'hBEEF);
        step(1, "wrap");
        chk("wrap.zero", {16'd0, bus.seq_o}, 32'd0);
        chk("wrap.p1", bus.p_sm_1_o, 32'hC0FFEE);

        // async reset while frozen with a pending capture
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 3, 0, 0, 0, 0, 32'h900 + i, 32'hA00 + i);
            step(1, "ar.run");
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 3, 0, 1, 0, 0, 32'hB00 + i, 32'hC00 + i);
            step(1, "ar.hold");
        end
        chk("ar.pend", {24'd0, bus.drop_cnt_o} != 0, 32'd1);
        #2;
        arst_ni = 1'b0;
        #1;
        chk("ar.p1", bus.p_sm_1_o, 32'd0);
        chk("ar.p2", bus.p_sm_2_o, 32'd0);
        chk("ar.valid", {31'd0, bus.valid_o}, 32'd0);
        chk("ar.seq", {16'd0, bus.seq_o}, 32'd0);
        chk("ar.drop", {24'd0, bus.drop_cnt_o}, 32'd0);
        chk("ar.state", {30'd0, bus.state_o}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 32'hD00, 32'hE00);
        model_reset();
        @(negedge clk_i);
        arst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, "ar.post");
            chk("ar.noseq", {16'd0, bus.seq_o}, 32'd0);
            chk("ar.nostate", {30'd0, bus.state_o}, 32'd0);
        end

        // random traffic
        fr = 0; en = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) fr = ~fr;
            if ($urandom_range(9) == 0) en = ~en;
            drive(en, 16'($urandom_range(4)), $urandom_range(5) == 0, fr,
                  $urandom_range(3) == 0, $urandom_range(15) == 0,
                  $urandom, $urandom);
            step(1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/monim_sm_ctrl.md
# monim_sm_ctrl

Sampling scheduler for the two monitor channels: decides when the 32-bit sample pair is captured and presented to the AXI-Lite monitor register bank. Issues periodic or one-shot captures and freezes the presented pair while software reads it. Counts captures lost during the freeze and performs a catch-up capture on release. Sits between the raw sample sources and the AXI-Lite monitor, in place of a free-running pass-through register.

## Interface
- DW, 32, width of each sample channel
- PW, 16, width of the period register

- clk_i  in  1  system clock, all logic on rising edge
- arst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  periodic sampling enable, level
- period_i  in  PW  sample period minus one, in cycles
- single_i  in  1  one-shot capture request, 1-cycle pulse
- freeze_i  in  1  hold presented pair; level, driven by the AXI-Lite reader
- ack_i  in  1  reader consumed current pair, 1-cycle pulse
- clr_i  in  1  clear drop_cnt_o, 1-cycle pulse
- data_p_sm_1_i  in  DW  channel 1 sample
- data_p_sm_2_i  in  DW  channel 2 sample
- p_sm_1_o  out  DW  captured channel 1
- p_sm_2_o  out  DW  captured channel 2
- valid_o  out  1  unread capture present
- seq_o  out  16  capture sequence number
- drop_cnt_o  out  8  captures lost while frozen, saturating
- state_o  out  2  FSM state: IDLE=0, RUN=1, HOLD=2, CATCH=3

## Operation
- Reset (arst_ni low, any time): all outputs 0, state IDLE, counter 0, pending 0. Reset mid-operation discards any pending capture.
- Capture: p_sm_1_o/p_sm_2_o load both inputs on the same edge. valid_o set. seq_o increments, wrapping 0xFFFF->0x0000.
- Tick: in RUN or HOLD with enable_i=1, when counter==0. Counter then reloads period_i; otherwise it decrements.
- period_i is sampled only at load or reload.
- Request: a tick or single_i.
- IDLE
  - freeze_i=1 -> HOLD. Freeze has priority.
  - else enable_i=1 -> RUN, counter<=period_i.
  - single_i=1 with freeze_i=0 -> capture.
  - freeze_i=1 and enable_i=1 together -> HOLD, counter loaded.
- RUN
  - freeze_i=1 -> HOLD. A request in the same cycle is dropped.
  - else enable_i=0 -> IDLE, counter cleared. A request in the same cycle is still captured.
  - else request -> capture. single_i also reloads the counter. Tick and single_i together give one capture.
- HOLD
  - Outputs frozen. Counter runs while enable_i=1 and is cleared while enable_i=0.
  - Each request sets pending and increments drop_cnt_o, saturating at 255. Tick and single_i together count 1.
  - freeze_i=0 -> CATCH if pending (or a request arrives this cycle), else RUN if enable_i, else IDLE.
- CATCH (one cycle)
  - Unconditional capture. Pending cleared. Any request this cycle merges into the capture; no extra drop is counted.
  - Next state: HOLD if freeze_i, else RUN if enable_i, else IDLE.
  - Counter keeps running.
- valid_o
  - Cleared by ack_i.
  - Capture and ack_i in the same cycle -> valid_o=1.
  - ack_i with valid_o=0 is ignored.
- drop_cnt_o
  - clr_i -> 0.
  - clr_i and a drop in the same cycle -> 1.

## Timing
- Output latency: data present at input during the request cycle appears on the outputs one cycle later, registered. valid_o and seq_o update on that same edge.
- Periodic spacing: period_i=N gives one capture every N+1 cycles. The first capture occurs N+1 cycles after the edge that enters RUN.
- period_i=0 gives a capture every cycle in RUN.
- Freeze release: freeze_i falls at edge k -> CATCH during cycle k+1 -> new pair visible after edge k+2.
- No combinational paths from inputs to outputs.

## Test plan
- Periodic: period_i=3, enable_i=1 from reset release -> captures every 4 cycles. seq_o steps 1,2,3. Outputs match the inputs of the tick cycle.
- One-shot: IDLE, data=0xA5A5_0001/0x5A5A_0002, single_i pulse -> next cycle p_sm outputs equal those values, valid_o=1, seq_o=1. ack_i -> valid_o=0.
- Freeze: period_i=1, freeze_i high for 6 cycles -> drop_cnt_o=3, outputs unchanged. After release, CATCH captures once and seq_o advances by exactly 1.
- Simultaneous: capture with ack_i -> valid_o stays 1. clr_i with a drop -> drop_cnt_o=1. Tick with single_i -> one capture.
- Saturation/wrap: 300 drops -> drop_cnt_o=255. Preload 0xFFFF captures -> next capture gives seq_o=0.
- Reset: assert arst_ni low mid-RUN while frozen with pending -> all outputs 0 immediately, state IDLE. No catch-up capture after release.
